// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader
//
// Byte-stream programming port for the instruction memory. It is the write side
// that sits opposite the PC-driven fetch port. A load is a length-prefixed,
// checksummed byte stream on a valid/ready handshake:
//
//   N (words) | 4*N payload bytes | checksum (sum of payload mod 256)
//
// Each accepted payload byte k becomes one byte write at address k. Addresses
// are big-endian within a word, so byte 4w carries instruction bits [31:24].
// The pipeline is held in reset (o_cpu_rst_n = 0) until a complete image has
// been loaded and its checksum matches.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   i_start      one-cycle load request (honoured in IDLE, DONE, ERR only)
//   i_in_valid   stream byte present
//   i_in_data    stream byte
//   o_in_ready   loader accepts a byte this cycle (LEN, DATA, CSUM)
//   o_im_we      byte write strobe to the instruction store
//   o_im_addr    byte address of the write
//   o_im_wdata   byte to write
//   o_busy       load in progress
//   o_done       image loaded and verified (level)
//   o_err        load aborted (level)
//   o_cpu_rst_n  active-low pipeline reset; high only in DONE
// -----------------------------------------------------------------------------
module im_loader #(
  parameter int DEPTH = 40            // store size in bytes, multiple of 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_in_valid,
  input  logic [7:0]  i_in_data,
  output logic        o_in_ready,
  output logic        o_im_we,
  output logic [31:0] o_im_addr,
  output logic [7:0]  o_im_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_cpu_rst_n
);

  // Largest image the store can hold, in words. Derived, never overridden.
  localparam int MAXW = DEPTH / 4;
  // Counter must be able to represent DEPTH itself (6 bits for 40 bytes).
  localparam int CW   = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;        // index of the next payload byte
  logic [CW-1:0]   r_total;      // payload length in bytes (4*N)
  logic [7:0]      r_sum;        // running payload sum mod 256
  logic            r_in_ready;
  logic            r_im_we;
  logic [31:0]     r_im_addr;
  logic [7:0]      r_im_wdata;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic            r_cpu_rst_n;

  logic            w_xfer;
  logic            w_len_bad;
  logic            w_last_byte;

  // r_in_ready is a register, so the handshake has no path from i_in_valid.
  assign w_xfer      = i_in_valid & r_in_ready;
  // N is an unsigned byte: 255 is simply too large, never a wrapped small value.
  assign w_len_bad   = (i_in_data == 8'd0) || (i_in_data > 8'(MAXW));
  assign w_last_byte = (r_cnt == r_total - CW'(1));

  // NOTE: every register here is sequential state, so each is assigned with
  // non-blocking (<=) assignments; blocking ones would let later statements in
  // the same block see half-updated values and break the simulation/synthesis
  // match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_total     <= '0;
      r_sum       <= '0;
      r_in_ready  <= 1'b0;
      r_im_we     <= 1'b0;
      r_im_addr   <= '0;
      r_im_wdata  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse per accepted payload byte.
      r_im_we <= 1'b0;

      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          // in_ready is low here, so a byte offered with start is not taken.
          if (i_start) begin
            r_state     <= S_LEN;
            r_cnt       <= '0;
            r_total     <= '0;
            r_sum       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b1;
          end
        end

        S_LEN: begin
          if (w_xfer) begin
            if (w_len_bad) begin
              r_state    <= S_ERR;
              r_err      <= 1'b1;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
            end else begin
              // N <= MAXW here, so 4*N always fits in CW bits.
              r_total <= CW'({i_in_data, 2'b00});
              r_state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_xfer) begin
            r_im_we    <= 1'b1;
            r_im_addr  <= 32'(r_cnt);
            r_im_wdata <= i_in_data;
            r_sum      <= r_sum + i_in_data;
            r_cnt      <= r_cnt + CW'(1);
            if (w_last_byte) begin
              r_state <= S_CSUM;
            end
          end
        end

        S_CSUM: begin
          if (w_xfer) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            // Bytes already written stay in the store on a mismatch.
            if (i_in_data == r_sum) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_cpu_rst_n <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_im_we     = r_im_we;
  assign o_im_addr   = r_im_addr;
  assign o_im_wdata  = r_im_wdata;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_cpu_rst_n = r_cpu_rst_n;

endmodule
